// File: rtl/pe_array_seq_controller_v2.sv
`timescale 1ns/1ps
// Sequences MAC enables, ping-pong RF selects and actv/wgt/psum addresses for a ROW x COL PE array, tile by tile.
// Latency: start to first MAC_en is 2 cycles with buffers preloaded. Defining PE_PIPE_EN adds 1 cycle to the array-side outputs.
// Backpressure: stalls in WAIT until the selected actv/wgt RF pair is full, and holds in DRAIN until su_add_finish.
module pe_array_seq_controller_v2 #(
    parameter int ROW                = 16,
    parameter int COL                = 16,
    parameter int ACTV_ADDR_BITWIDTH = 2,
    parameter int WGT_ADDR_BITWIDTH  = 2,
    parameter int PSUM_ADDR_BITWIDTH = 2,
    parameter int TILE_BITWIDTH      = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [ACTV_ADDR_BITWIDTH:0]     cfg_k_len,
    input  logic [PSUM_ADDR_BITWIDTH:0]     cfg_psum_len,
    input  logic [TILE_BITWIDTH-1:0]        cfg_num_tiles,
    input  logic [ROW*COL-1:0]              mac_mask,
    input  logic                            actv_buf1_send_finish,
    input  logic                            actv_buf2_send_finish,
    input  logic                            wgt_buf1_send_finish,
    input  logic                            wgt_buf2_send_finish,
    input  logic                            su_add_finish,
    output logic                            actv_rf1_need_data,
    output logic                            actv_rf2_need_data,
    output logic                            wgt_rf1_need_data,
    output logic                            wgt_rf2_need_data,
    output logic [ROW*COL-1:0]              MAC_en,
    output logic                            actv_sel,
    output logic                            wgt_sel,
    output logic [ACTV_ADDR_BITWIDTH-1:0]   actv_r_addr,
    output logic [WGT_ADDR_BITWIDTH-1:0]    wgt_r_addr,
    output logic                            psum_en,
    output logic [PSUM_ADDR_BITWIDTH-1:0]   psum_addr,
    output logic [PSUM_ADDR_BITWIDTH-1:0]   psum_write_addr,
    output logic                            pe_psum_finish,
    output logic                            conv_finish,
    output logic                            turn_off,
    output logic                            busy
);

    typedef enum logic [2:0] {IDLE, WAIT, RUN, DRAIN, DONE} state_t;

    localparam logic [ACTV_ADDR_BITWIDTH:0]   K_LEN_ONE = 1;
    localparam logic [PSUM_ADDR_BITWIDTH:0]   P_LEN_ONE = 1;
    localparam logic [TILE_BITWIDTH-1:0]      TILE_ONE  = 1;
    localparam logic [ACTV_ADDR_BITWIDTH-1:0] K_ONE     = 1;
    localparam logic [PSUM_ADDR_BITWIDTH-1:0] P_ONE     = 1;

    state_t                          state;
    logic                            sel;
    logic [ACTV_ADDR_BITWIDTH-1:0]   k, k_last;
    logic [PSUM_ADDR_BITWIDTH-1:0]   p, p_last;
    logic [TILE_BITWIDTH-1:0]        tile, tile_last;
    logic [ROW*COL-1:0]              mask_q;
    logic [1:0]                      actv_full, wgt_full;

    logic in_run, retire, cur_ready, other_ready;
    assign in_run      = (state == RUN);
    assign retire      = in_run && (k == k_last) && (p == p_last);
    assign cur_ready   = sel ? (actv_full[1] & wgt_full[1]) : (actv_full[0] & wgt_full[0]);
    assign other_ready = sel ? (actv_full[0] & wgt_full[0]) : (actv_full[1] & wgt_full[1]);

    // Buffer full flags: a retiring tile frees its pair, and that release beats a same-cycle fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            actv_full <= '0;
            wgt_full  <= '0;
        end else begin
            actv_full[0] <= (retire && !sel) ? 1'b0 : (actv_full[0] | actv_buf1_send_finish);
            actv_full[1] <= (retire &&  sel) ? 1'b0 : (actv_full[1] | actv_buf2_send_finish);
            wgt_full[0]  <= (retire && !sel) ? 1'b0 : (wgt_full[0]  | wgt_buf1_send_finish);
            wgt_full[1]  <= (retire &&  sel) ? 1'b0 : (wgt_full[1]  | wgt_buf2_send_finish);
        end
    end

    // Sequencer: latches configuration on start, walks k inside p per tile, swaps buffers with no bubble when possible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= 1'b0;
            k         <= '0;
            p         <= '0;
            tile      <= '0;
            k_last    <= '0;
            p_last    <= '0;
            tile_last <= '0;
            mask_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WAIT;
                        k_last    <= (cfg_k_len == '0) ? '0 : ACTV_ADDR_BITWIDTH'(cfg_k_len - K_LEN_ONE);
                        p_last    <= (cfg_psum_len == '0) ? '0 : PSUM_ADDR_BITWIDTH'(cfg_psum_len - P_LEN_ONE);
                        tile_last <= (cfg_num_tiles == '0) ? '0 : (cfg_num_tiles - TILE_ONE);
                        mask_q    <= mac_mask;
                        sel       <= 1'b0;
                        k         <= '0;
                        p         <= '0;
                        tile      <= '0;
                    end
                end
                WAIT: begin
                    if (cur_ready) state <= RUN;
                end
                RUN: begin
                    if (k == k_last) begin
                        k <= '0;
                        if (p == p_last) begin
                            p    <= '0;
                            tile <= tile + TILE_ONE;
                            sel  <= ~sel;
                            if (tile == tile_last) state <= DRAIN;
                            else if (other_ready)  state <= RUN;
                            else                   state <= WAIT;
                        end else begin
                            p <= p + P_ONE;
                        end
                    end else begin
                        k <= k + K_ONE;
                    end
                end
                DRAIN: begin
                    if (su_add_finish) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    sel   <= 1'b0;
                    k     <= '0;
                    p     <= '0;
                    tile  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array-side values decoded from state and counters; addresses and enables are forced to 0 outside RUN.
    logic [ROW*COL-1:0]            mac_en_c;
    logic [ACTV_ADDR_BITWIDTH-1:0] actv_addr_c;
    logic [WGT_ADDR_BITWIDTH-1:0]  wgt_addr_c;
    logic [PSUM_ADDR_BITWIDTH-1:0] psum_addr_c;
    logic                          psum_en_c;
    logic [PSUM_ADDR_BITWIDTH-1:0] psum_wr_q;

    assign mac_en_c    = in_run ? mask_q : '0;
    assign actv_addr_c = in_run ? k : '0;
    assign wgt_addr_c  = in_run ? WGT_ADDR_BITWIDTH'(k) : '0;
    assign psum_addr_c = in_run ? p : '0;
    assign psum_en_c   = in_run && (tile != '0);

    // Psum write address trails the read address by one cycle so the PE writes back where it read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) psum_wr_q <= '0;
        else       psum_wr_q <= psum_addr_c;
    end

`ifdef PE_PIPE_EN
    // Extra retiming stage on every array-side output to ease timing into a large array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MAC_en          <= '0;
            actv_sel        <= 1'b0;
            wgt_sel         <= 1'b0;
            actv_r_addr     <= '0;
            wgt_r_addr      <= '0;
            psum_en         <= 1'b0;
            psum_addr       <= '0;
            psum_write_addr <= '0;
        end else begin
            MAC_en          <= mac_en_c;
            actv_sel        <= sel;
            wgt_sel         <= sel;
            actv_r_addr     <= actv_addr_c;
            wgt_r_addr      <= wgt_addr_c;
            psum_en         <= psum_en_c;
            psum_addr       <= psum_addr_c;
            psum_write_addr <= psum_wr_q;
        end
    end
`else
    assign MAC_en          = mac_en_c;
    assign actv_sel        = sel;
    assign wgt_sel         = sel;
    assign actv_r_addr     = actv_addr_c;
    assign wgt_r_addr      = wgt_addr_c;
    assign psum_en         = psum_en_c;
    assign psum_addr       = psum_addr_c;
    assign psum_write_addr = psum_wr_q;
`endif

    assign busy               = (state != IDLE);
    assign pe_psum_finish     = (state == DRAIN);
    assign conv_finish        = (state == DONE);
    assign turn_off           = (state == DONE);
    assign actv_rf1_need_data = busy & ~actv_full[0];
    assign actv_rf2_need_data = busy & ~actv_full[1];
    assign wgt_rf1_need_data  = busy & ~wgt_full[0];
    assign wgt_rf2_need_data  = busy & ~wgt_full[1];

endmodule
